// File: rtl/mem_access_ctrl.sv
// RV32I load/store sequencer between execute and a handshaked data memory.
// Optional misaligned-access trap: define MISALIGN_TRAP_EN.
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned CNT_W          = 16
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        lsu_req_in,
   input  logic        lsu_we_in,
   input  logic [2:0]  lsu_funct3_in,
   input  logic [31:0] lsu_addr_in,
   input  logic [31:0] lsu_wdata_in,
   output logic        lsu_busy_out,
   output logic        lsu_done_out,
   output logic [31:0] lsu_rdata_out,
   output logic        lsu_err_out,
   output logic        dmem_req_out,
   output logic        dmem_we_out,
   output logic [31:0] dmem_addr_out,
   output logic [3:0]  dmem_wstrb_out,
   output logic [31:0] dmem_wdata_out,
   input  logic        dmem_ack_in,
   input  logic [31:0] dmem_rdata_in
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_RESP
   } state_t;

   state_t state_q, state_d;

   logic             we_q;
   logic [2:0]       f3_q;
   logic [1:0]       off_q;
   logic [29:0]      word_q;
   logic [3:0]       wstrb_q;
   logic [31:0]      wdata_q;
   logic [31:0]      rdata_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;

   logic [1:0]  off_in;
   logic [3:0]  st_strb;
   logic [31:0] st_data;
   logic        mis;
   logic        to_hit;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_ext;

   assign off_in = lsu_addr_in[1:0];

   always_comb begin
      st_strb = 4'b1111;
      st_data = lsu_wdata_in;
      case (lsu_funct3_in)
         3'b000: begin
            st_strb = 4'b0001 << off_in;
            st_data = {4{lsu_wdata_in[7:0]}};
         end
         3'b001: begin
            st_strb = 4'b0011 << {off_in[1], 1'b0};
            st_data = {2{lsu_wdata_in[15:0]}};
         end
         default: ;
      endcase
   end

`ifdef MISALIGN_TRAP_EN
   logic is_half;
   logic is_word;

   // Stores only know SB/SH; everything else is sized as a word.
   assign is_half = lsu_we_in ? (lsu_funct3_in == 3'b001)
                              : (lsu_funct3_in[1:0] == 2'b01);
   assign is_word = lsu_we_in ? (lsu_funct3_in[2:1] != 2'b00)
                              : lsu_funct3_in[1];
   assign mis = (is_half & off_in[0]) | (is_word & (|off_in));
`else
   assign mis = 1'b0;
`endif

   assign to_hit = (TIMEOUT_CYCLES != 0) &&
                   (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   assign ld_byte = dmem_rdata_in[{off_q, 3'b000} +: 8];
   assign ld_half = dmem_rdata_in[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      ld_ext = dmem_rdata_in;
      case (f3_q[1:0])
         2'b00:   ld_ext = {{24{~f3_q[2] & ld_byte[7]}}, ld_byte};
         2'b01:   ld_ext = {{16{~f3_q[2] & ld_half[15]}}, ld_half};
         default: ld_ext = dmem_rdata_in;
      endcase
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (lsu_req_in) state_d = mis ? S_RESP : S_REQ;
         end
         S_REQ: begin
            if (dmem_ack_in || to_hit) state_d = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         we_q    <= 1'b0;
         f3_q    <= 3'b000;
         off_q   <= 2'b00;
         word_q  <= '0;
         wstrb_q <= 4'b0000;
         wdata_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               cnt_q <= '0;
               if (lsu_req_in) begin
                  we_q    <= lsu_we_in;
                  f3_q    <= lsu_funct3_in;
                  off_q   <= off_in;
                  word_q  <= lsu_addr_in[31:2];
                  wstrb_q <= lsu_we_in ? st_strb : 4'b0000;
                  wdata_q <= st_data;
                  err_q   <= mis;
                  if (mis) rdata_q <= '0;
               end
            end
            S_REQ: begin
               // Ack beats a coincident timeout.
               if (dmem_ack_in) begin
                  err_q   <= 1'b0;
                  rdata_q <= we_q ? 32'd0 : ld_ext;
                  cnt_q   <= '0;
               end else if (to_hit) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign lsu_busy_out   = (state_q != S_IDLE);
   assign lsu_done_out   = (state_q == S_RESP);
   assign lsu_err_out    = lsu_done_out & err_q;
   assign lsu_rdata_out  = rdata_q;
   assign dmem_req_out   = (state_q == S_REQ);
   assign dmem_we_out    = dmem_req_out & we_q;
   assign dmem_addr_out  = {word_q, 2'b00};
   assign dmem_wstrb_out = wstrb_q;
   assign dmem_wdata_out = wdata_q;

endmodule
